// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg - shared widths and the l=4 truncated approximate multiplier.
//
// Contents:
//   X_W      operand width (8)
//   Z_W      product width (16)
//   L_TRUNC  number of truncated low multiplicand bits (4)
//   approx_mul_l4(x, y)  approximate unsigned product. The upper nibble of x
//                        is multiplied exactly. The partial products dropped
//                        from the low nibble are replaced by a fixed set of
//                        compensation terms. The largest result is 64528, so
//                        the sum never overflows Z_W.
package approx_mul_pkg;

  localparam int X_W     = 8;
  localparam int Z_W     = 16;
  localparam int L_TRUNC = 4;

  function automatic logic [Z_W-1:0] approx_mul_l4(input logic [X_W-1:0] x,
                                                   input logic [X_W-1:0] y);
    logic [Z_W-1:0] z;
    z = (Z_W'(y) * Z_W'(x[X_W-1:L_TRUNC])) << L_TRUNC;
    // Compensation for the dropped x[3:0]*y partial products.
    z = z + (Z_W'((x[0] & y[7]) | (x[1] & y[6])) << 8);
    z = z + (Z_W'((x[2] & y[7]) & (x[3] & y[6])) << 9);
    z = z + (Z_W'(x[3] & y[7]) << 10);
    z = z + (Z_W'(x[1] & y[7]) << 8);
    z = z + (Z_W'((x[2] & y[7]) | (x[3] & y[6])) << 9);
    z = z + (Z_W'((x[2] & y[6]) | (x[3] & y[4])) << 8);
    z = z + (Z_W'((x[2] & y[5]) & (x[3] & y[5])) << 8);
    z = z + (Z_W'((x[2] & y[5]) | (x[3] & y[5])) << 8);
    return z;
  endfunction

endpackage

// File: rtl/approx_mul_arbiter_if.sv
// approx_mul_arbiter_if - request/response bundle between the accelerator
// lanes and the shared approximate multiplier.
//
// Signals:
//   req_valid[NUM_REQ]   per-lane request valid
//   req_ready[NUM_REQ]   per-lane accept, one-hot or zero
//   req_x / req_y        packed 8-bit operands, lane i at [8i+7:8i]
//   req_exact[NUM_REQ]   per-lane exact-product request (APPROX_MUL_EXACT_EN only)
//   rsp_valid/rsp_ready  response handshake
//   rsp_z                16-bit product
//   rsp_id               originating lane index
// Modports: master = lanes + response consumer, slave = arbiter.
// Optional feature macro: APPROX_MUL_EXACT_EN.
interface approx_mul_arbiter_if
  import approx_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [X_W*NUM_REQ-1:0] req_x;
  logic [X_W*NUM_REQ-1:0] req_y;
`ifdef APPROX_MUL_EXACT_EN
  logic [NUM_REQ-1:0]     req_exact;
`endif
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [Z_W-1:0]         rsp_z;
  logic [ID_W-1:0]        rsp_id;

`ifdef APPROX_MUL_EXACT_EN
  modport master (output req_valid, req_x, req_y, req_exact, rsp_ready,
                  input  req_ready, rsp_valid, rsp_z, rsp_id);
  modport slave  (input  req_valid, req_x, req_y, req_exact, rsp_ready,
                  output req_ready, rsp_valid, rsp_z, rsp_id);
`else
  modport master (output req_valid, req_x, req_y, rsp_ready,
                  input  req_ready, rsp_valid, rsp_z, rsp_id);
  modport slave  (input  req_valid, req_x, req_y, rsp_ready,
                  output req_ready, rsp_valid, rsp_z, rsp_id);
`endif

endinterface

// File: rtl/approx_mul_core_l4.sv
// approx_mul_core_l4 - combinational 8x8 multiplier sitting between the
// operand register and the result register.
//
// Ports:
//   x, y   8-bit unsigned operands
//   exact  select exact x*y instead of the approximation (APPROX_MUL_EXACT_EN only)
//   z      16-bit product
module approx_mul_core_l4
  import approx_mul_pkg::*;
(
  input  logic [X_W-1:0] x,
  input  logic [X_W-1:0] y,
  output logic [Z_W-1:0] z
`ifdef APPROX_MUL_EXACT_EN
  ,
  input  logic           exact
`endif
);

`ifdef APPROX_MUL_EXACT_EN
  assign z = exact ? Z_W'(x) * Z_W'(y) : approx_mul_l4(x, y);
`else
  assign z = approx_mul_l4(x, y);
`endif

endmodule

// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter - round-robin sharing of one approximate multiplier
// among NUM_REQ lanes, with a 2-stage pipeline (operands -> result).
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   bus        approx_mul_arbiter_if.slave (requests in, tagged responses out)
//   txn_count  completed response handshakes, wraps at 2^CNT_W
// Optional feature macro: APPROX_MUL_EXACT_EN (per-request exact product).
module approx_mul_arbiter
  import approx_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
)(
  input  logic                 clk,
  input  logic                 rst_n,
  approx_mul_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     txn_count
);

  logic               s1_vld;
  logic [X_W-1:0]     s1_x;
  logic [X_W-1:0]     s1_y;
  logic [ID_W-1:0]    s1_id;
  logic               s2_vld;
  logic [Z_W-1:0]     rsp_z_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [ID_W-1:0]    rr_ptr;

  logic               adv2;
  logic               accept;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic               req_hs;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [Z_W-1:0]     core_z;

  // Stage 1 moves forward when stage 2 is empty or is being drained; a new
  // request fits whenever stage 1 is empty or moving forward this cycle.
  assign adv2   = s1_vld && (!s2_vld || bus.rsp_ready);
  assign accept = !s1_vld || adv2;

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ (which need
  // not be a power of two).
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  // Readies are held low while reset is asserted so no lane sees a
  // handshake that the reset edge would discard.
  assign req_hs = rst_n && accept && grant_vld;

  always_comb begin
    req_ready_c = '0;
    if (req_hs) req_ready_c[grant_id] = 1'b1;
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = s2_vld;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_id    = rsp_id_q;

  // Control state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      rsp_z_q   <= '0;
      rsp_id_q  <= '0;
      rr_ptr    <= '0;
      txn_count <= '0;
    end else begin
      if (req_hs) begin
        s1_vld <= 1'b1;
        rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end else if (adv2) begin
        s1_vld <= 1'b0;
      end

      if (adv2) begin
        s2_vld   <= 1'b1;
        rsp_z_q  <= core_z;
        rsp_id_q <= s1_id;
      end else if (bus.rsp_ready) begin
        s2_vld <= 1'b0;
      end

      if (s2_vld && bus.rsp_ready) txn_count <= txn_count + 1'b1;
    end
  end

  // Stage-1 payload.
  // NOTE: payload registers are not reset; s1_vld qualifies them, so a reset
  // here would only cost routing on the reset net.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      s1_x  <= bus.req_x[X_W*grant_id +: X_W];
      s1_y  <= bus.req_y[X_W*grant_id +: X_W];
      s1_id <= grant_id;
    end
  end

`ifdef APPROX_MUL_EXACT_EN
  logic s1_exact;

  always_ff @(posedge clk) begin
    if (req_hs) s1_exact <= bus.req_exact[grant_id];
  end

  approx_mul_core_l4 u_core (
    .x     (s1_x),
    .y     (s1_y),
    .z     (core_z),
    .exact (s1_exact)
  );
`else
  approx_mul_core_l4 u_core (
    .x (s1_x),
    .y (s1_y),
    .z (core_z)
  );
`endif

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// tb_approx_mul_arbiter - self-checking bench for approx_mul_arbiter.
// A cycle-level reference model (in-flight queue, round-robin pointer,
// arithmetic product formula) predicts every output each cycle; directed
// cases add literal expectations. Honours APPROX_MUL_EXACT_EN.
module tb_approx_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] txn_count;

  always #5 clk = ~clk;

  approx_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  approx_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .txn_count (txn_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", tag, $time, got, got, exp, exp);
    end
  endtask

  // Reference product, computed straight from the formula with integers.
  function automatic int pb(int x, int y, int i, int j);
    return ((x >> i) & 1) & ((y >> j) & 1);
  endfunction

  function automatic int ref_f(int x, int y, bit exact);
    if (exact) return x * y;
    return y * (x / 16) * 16
         + 256  * (pb(x,y,0,7) | pb(x,y,1,6))
         + 512  * (pb(x,y,2,7) & pb(x,y,3,6))
         + 1024 *  pb(x,y,3,7)
         + 256  *  pb(x,y,1,7)
         + 512  * (pb(x,y,2,7) | pb(x,y,3,6))
         + 256  * (pb(x,y,2,6) | pb(x,y,3,4))
         + 256  * (pb(x,y,2,5) & pb(x,y,3,5))
         + 256  * (pb(x,y,2,5) | pb(x,y,3,5));
  endfunction

  // Model: accepted transactions in order; the head is visible on the
  // response port once it has reached the result register.
  typedef struct { int z; int id; } item_t;
  item_t q[$];
  bit    head_vis = 1'b0;
  int    rr       = 0;
  int    cnt      = 0;

  logic [NUM_REQ-1:0] obs_ready;
  logic               obs_valid;
  logic [15:0]        obs_z;
  logic [ID_W-1:0]    obs_id;
  logic [CNT_W-1:0]   obs_cnt;

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the model across the coming rising edge.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [8*NUM_REQ-1:0] xs,
                      input logic [8*NUM_REQ-1:0] ys, input logic [NUM_REQ-1:0] ex,
                      input logic rdy, input logic rst_val);
    int n_s1;
    bit adv2, acc, consume, exq;
    int g;
    int idx;
    logic [NUM_REQ-1:0] exp_ready;
    @(negedge clk);
    rst_n         = rst_val;
    bus.req_valid = v;
    bus.req_x     = xs;
    bus.req_y     = ys;
    bus.rsp_ready = rdy;
`ifdef APPROX_MUL_EXACT_EN
    bus.req_exact = ex;
`endif
    #1;
    n_s1 = q.size() - int'(head_vis);
    adv2 = (n_s1 == 1) && (!head_vis || rdy);
    acc  = (n_s1 == 0) || adv2;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (rr + k) % NUM_REQ;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_ready = '0;
    if (rst_val && acc && g >= 0) exp_ready[g] = 1'b1;

    obs_ready = bus.req_ready;
    obs_valid = bus.rsp_valid;
    obs_z     = bus.rsp_z;
    obs_id    = bus.rsp_id;
    obs_cnt   = txn_count;

    check("req_ready", obs_ready, exp_ready);
    check("rsp_valid", obs_valid, head_vis);
    if (head_vis) begin
      check("rsp_z", obs_z, q[0].z);
      check("rsp_id", obs_id, q[0].id);
    end
    check("txn_count", obs_cnt, cnt % (1 << CNT_W));

    if (!rst_val) begin
      q.delete();
      head_vis = 1'b0;
      rr = 0;
      cnt = 0;
    end else begin
      consume = head_vis && rdy;
      if (consume) begin
        void'(q.pop_front());
        cnt++;
      end
      if (adv2) head_vis = 1'b1;
      else if (consume) head_vis = 1'b0;
      if (exp_ready != '0) begin
`ifdef APPROX_MUL_EXACT_EN
        exq = ex[g];
`else
        exq = 1'b0;
`endif
        q.push_back('{ref_f(int'(xs[8*g +: 8]), int'(ys[8*g +: 8]), exq), g});
        rr = (g + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, '0, '0, rdy, 1'b1);
  endtask

  // Lone request from lane id into an empty pipeline, response 2 cycles later.
  task automatic one_req(input int id, input int x, input int y, input bit ex,
                         input int exp_z, input string tag);
    logic [NUM_REQ-1:0]   v, e;
    logic [8*NUM_REQ-1:0] xs, ys;
    v = '0; v[id] = 1'b1;
    e = '0; e[id] = ex;
    xs = '0; xs[8*id +: 8] = 8'(x);
    ys = '0; ys[8*id +: 8] = 8'(y);
    step(v, xs, ys, e, 1'b1, 1'b1);
    check({tag, "_hs"}, obs_ready, v);
    idle(1'b1);
    check({tag, "_lat1"}, obs_valid, 0);
    idle(1'b1);
    check({tag, "_valid"}, obs_valid, 1);
    check({tag, "_z"}, obs_z, exp_z);
    check({tag, "_id"}, obs_id, id);
    idle(1'b1);
  endtask

  function automatic logic [8*NUM_REQ-1:0] rand_bytes();
    logic [8*NUM_REQ-1:0] r;
    for (int i = 0; i < NUM_REQ; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  initial begin
    int n_acc;
    logic [NUM_REQ-1:0] all_v;
    all_v = '1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
`ifdef APPROX_MUL_EXACT_EN
    bus.req_exact = '0;
`endif
    repeat (3) @(posedge clk);

    // Reset state with reset released.
    idle(1'b1);
    check("reset_rsp_valid", obs_valid, 0);
    check("reset_txn_count", obs_cnt, 0);

    // Directed products.
    one_req(2, 255, 255, 1'b0, 64528, "max_l2");
    check("txn_count_first", obs_cnt, 1);
    one_req(0, 15, 200, 1'b0, 2816, "x15_y200");
    one_req(1, 0, int'($urandom_range(0, 255)), 1'b0, 0, "x0");
`ifdef APPROX_MUL_EXACT_EN
    one_req(2, 255, 255, 1'b1, 65025, "exact_max");
    one_req(2, 255, 255, 1'b0, 64528, "approx_max");
`endif
    one_req(3, 16, 1, 1'b0, 16, "x16_y1");

    // All lanes busy, no backpressure: rotating grants, one per cycle.
    for (int k = 0; k < 8; k++) begin
      step(all_v, rand_bytes(), rand_bytes(), 4'($urandom), 1'b1, 1'b1);
      check("rr_grant", obs_ready, 4'b0001 << (k % 4));
    end
    repeat (3) idle(1'b1);

    // Backpressure: only two requests fit, outputs held by the model checks.
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      step(all_v, rand_bytes(), rand_bytes(), 4'($urandom), 1'b0, 1'b1);
      if (obs_ready != '0) n_acc++;
    end
    check("bp_accepted", n_acc, 2);
    check("bp_ready_low", obs_ready, 0);
    repeat (4) idle(1'b1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom), rand_bytes(), rand_bytes(), 4'($urandom),
           1'($urandom_range(0, 3) != 0), 1'b1);
    end

    // Reset with both stages full.
    repeat (3) step(all_v, rand_bytes(), rand_bytes(), '0, 1'b0, 1'b1);
    step(all_v, rand_bytes(), rand_bytes(), '0, 1'b0, 1'b0);
    check("rst_ready_low", obs_ready, 0);
    step(4'b1010, rand_bytes(), rand_bytes(), '0, 1'b1, 1'b1);
    check("post_rst_valid", obs_valid, 0);
    check("post_rst_count", obs_cnt, 0);
    check("post_rst_grant", obs_ready, 4'b0010);
    repeat (4) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
